// File: rtl/vga_pixel_fetch.sv
// VGA scanout stage: prefetches raster-order framebuffer words through a
// credit-limited read port into a pixel FIFO and drives registered RGB/sync.
module vga_pixel_fetch #(
  parameter int unsigned       ADDR_W          = 24,
  parameter logic [ADDR_W-1:0] FB_BASE         = {ADDR_W{1'b0}},
  parameter int unsigned       HRES            = 800,
  parameter int unsigned       VRES            = 600,
  parameter int unsigned       FIFO_DEPTH      = 16,
  parameter logic [23:0]       UNDERFLOW_COLOR = 24'hFF00FF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic              de_in,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ready,
  input  logic              mem_rvalid,
  input  logic [23:0]       mem_rdata,
  output logic [7:0]        vga_r,
  output logic [7:0]        vga_g,
  output logic [7:0]        vga_b,
  output logic              vga_hsync,
  output logic              vga_vsync,
  output logic              vga_de,
  output logic              underflow,
  input  logic              clear_underflow
);

  localparam int unsigned AW    = $clog2(FIFO_DEPTH);
  localparam int unsigned CW    = AW + 1;
  localparam int unsigned TOTAL = HRES * VRES;
  localparam int unsigned RCW   = $clog2(TOTAL + 1);

  localparam logic [CW-1:0]     CNT_ZERO = CW'(0);
  localparam logic [CW-1:0]     CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]     DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [AW-1:0]     PTR_ZERO = AW'(0);
  localparam logic [AW-1:0]     PTR_ONE  = AW'(1);
  localparam logic [RCW-1:0]    REQ_ZERO = RCW'(0);
  localparam logic [RCW-1:0]    REQ_ONE  = RCW'(1);
  localparam logic [RCW-1:0]    LAST_REQ = RCW'(TOTAL - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]     state;
  logic [1:0]     state_nxt;
  logic           vsync_prev;
  logic [RCW-1:0] req_count;
  logic [CW-1:0]  outstanding;
  logic [CW-1:0]  outstanding_nxt;
  logic [CW-1:0]  discard;
  logic [CW-1:0]  discard_nxt;
  logic [23:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]  rd_ptr;
  logic [AW-1:0]  wr_ptr;
  logic [CW-1:0]  fifo_count;
  logic [CW-1:0]  fifo_count_nxt;
  logic [CW:0]    credit_used;
  logic           mem_req_nxt;

  logic fs;
  logic accept;
  logic discard_hit;
  logic resp_live;
  logic fifo_empty;
  logic fifo_full;
  logic push;
  logic pop;
  logic underflow_set;

  assign fs            = enable && !vsync_in && vsync_prev;
  assign accept        = mem_req && mem_ready;
  assign discard_hit   = (discard != CNT_ZERO);
  assign resp_live     = mem_rvalid && !discard_hit;
  assign fifo_empty    = (fifo_count == CNT_ZERO);
  assign fifo_full     = (fifo_count == DEPTH_C);
  // A response landing on a frame-start cycle belongs to the old frame.
  assign push          = resp_live && !fs && !fifo_full;
  assign pop           = de_in && !fifo_empty;
  assign underflow_set = de_in && fifo_empty && ((state == FETCH) || (state == DONE));

  // Fetch state sequencing.
  always_comb begin
    state_nxt = state;
    if (!enable) begin
      state_nxt = IDLE;
    end else if (fs) begin
      state_nxt = FETCH;
    end else begin
      case (state)
        IDLE:    state_nxt = IDLE;
        FETCH: begin
          if (accept && (req_count == LAST_REQ)) begin
            state_nxt = DONE;
          end else begin
            state_nxt = FETCH;
          end
        end
        DONE:    state_nxt = DONE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Next-cycle occupancy; everything in flight at frame start becomes discard.
  always_comb begin
    outstanding_nxt = outstanding;
    discard_nxt     = discard;
    fifo_count_nxt  = fifo_count;
    if (fs) begin
      outstanding_nxt = CNT_ZERO;
      discard_nxt     = discard + outstanding + (accept ? CNT_ONE : CNT_ZERO)
                        - (mem_rvalid ? CNT_ONE : CNT_ZERO);
      fifo_count_nxt  = CNT_ZERO;
    end else begin
      outstanding_nxt = outstanding + (accept ? CNT_ONE : CNT_ZERO)
                        - (resp_live ? CNT_ONE : CNT_ZERO);
      discard_nxt     = discard - ((mem_rvalid && discard_hit) ? CNT_ONE : CNT_ZERO);
      fifo_count_nxt  = fifo_count + (push ? CNT_ONE : CNT_ZERO) - (pop ? CNT_ONE : CNT_ZERO);
    end
    credit_used = {1'b0, fifo_count_nxt} + {1'b0, outstanding_nxt};
    mem_req_nxt = (state_nxt == FETCH) && (credit_used < {1'b0, DEPTH_C});
  end

  // Request side: state, address and credit counters.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      vsync_prev  <= 1'b1;
      mem_req     <= 1'b0;
      mem_addr    <= FB_BASE;
      req_count   <= REQ_ZERO;
      outstanding <= CNT_ZERO;
      discard     <= CNT_ZERO;
    end else begin
      state       <= state_nxt;
      vsync_prev  <= vsync_in;
      mem_req     <= mem_req_nxt;
      outstanding <= outstanding_nxt;
      discard     <= discard_nxt;
      if (fs) begin
        mem_addr  <= FB_BASE;
        req_count <= REQ_ZERO;
      end else if (accept) begin
        mem_addr  <= mem_addr + ADDR_ONE;
        req_count <= req_count + REQ_ONE;
      end else begin
        mem_addr  <= mem_addr;
        req_count <= req_count;
      end
    end
  end

  // Pixel FIFO storage.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= mem_rdata;
    end
  end

  // Pixel FIFO pointers; frame start flushes.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_ptr     <= PTR_ZERO;
      wr_ptr     <= PTR_ZERO;
      fifo_count <= CNT_ZERO;
    end else if (fs) begin
      rd_ptr     <= PTR_ZERO;
      wr_ptr     <= PTR_ZERO;
      fifo_count <= CNT_ZERO;
    end else begin
      rd_ptr     <= pop ? rd_ptr + PTR_ONE : rd_ptr;
      wr_ptr     <= push ? wr_ptr + PTR_ONE : wr_ptr;
      fifo_count <= fifo_count_nxt;
    end
  end

  // Display outputs, one cycle behind the timing controller.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      {vga_r, vga_g, vga_b} <= 24'h000000;
      vga_hsync             <= 1'b1;
      vga_vsync             <= 1'b1;
      vga_de                <= 1'b0;
      underflow             <= 1'b0;
    end else begin
      vga_hsync <= hsync_in;
      vga_vsync <= vsync_in;
      vga_de    <= de_in;
      if (!de_in) begin
        {vga_r, vga_g, vga_b} <= 24'h000000;
      end else if (fifo_empty) begin
        {vga_r, vga_g, vga_b} <= UNDERFLOW_COLOR;
      end else begin
        {vga_r, vga_g, vga_b} <= fifo_mem[rd_ptr];
      end
      if (underflow_set) begin
        underflow <= 1'b1;
      end else if (clear_underflow) begin
        underflow <= 1'b0;
      end else begin
        underflow <= underflow;
      end
    end
  end

endmodule

// File: doc/vga_pixel_fetch.md
Name: vga_pixel_fetch

Overview:
- Scanout stage directly downstream of the VGA timing controller, in the same pixel-clock domain.
- Consumes that controller's hsync, vsync and active-video enable.
- Prefetches framebuffer pixels from memory through a credit-limited read interface into a small FIFO.
- Drives 24-bit RGB to the DAC, with hsync/vsync/de delayed to stay aligned with the pixel data.

Parameters:
- ADDR_W, 24, memory word-address width.
- FB_BASE, 0, word address of pixel (0,0); one 24-bit word per pixel, raster order.
- HRES, 800, active pixels per line.
- VRES, 600, active lines per frame.
- FIFO_DEPTH, 16, pixel FIFO entries; power of two, at least 4.
- UNDERFLOW_COLOR, 24'hFF00FF, RGB driven when a pixel is needed and the FIFO is empty.

Ports:
- clk  in  1  pixel clock
- reset_n  in  1  synchronous, active-low reset
- enable  in  1  scanout enable; 0 forces IDLE
- hsync_in  in  1  from timing controller, active low
- vsync_in  in  1  from timing controller, active low
- de_in  in  1  active-video enable (timing controller blank_n)
- mem_req  out  1  read request valid
- mem_addr  out  ADDR_W  read word address
- mem_ready  in  1  request accepted this cycle when mem_req && mem_ready
- mem_rvalid  in  1  read data valid; in-order, any latency of 1 cycle or more
- mem_rdata  in  24  pixel {R,G,B}
- vga_r, vga_g, vga_b  out  8 each  pixel colour
- vga_hsync, vga_vsync, vga_de  out  1 each  inputs delayed 1 cycle
- underflow  out  1  sticky underflow flag
- clear_underflow  in  1  clears underflow

Behaviour:
- Reset (reset_n=0 at a clk edge) gives:
  - state IDLE; FIFO empty; outstanding=0; discard=0; req_count=0; mem_addr=FB_BASE.
  - mem_req=0; vga_r/g/b=0; vga_hsync=1; vga_vsync=1; vga_de=0; underflow=0.
- Frame start (fs): vsync_in=0 while the registered previous vsync_in=1, and enable=1. On fs:
  - flush the FIFO;
  - discard <= outstanding;
  - outstanding <= 0;
  - req_count <= 0;
  - mem_addr <= FB_BASE;
  - state <= FETCH.
- States:
  - IDLE: mem_req=0. fs -> FETCH.
  - FETCH: mem_req=1 iff fifo_count + outstanding < FIFO_DEPTH. On each accept: mem_addr+1, req_count+1, outstanding+1. The accept that makes req_count = HRES*VRES moves the state to DONE.
  - DONE: mem_req=0. fs -> FETCH.
  - Any state with enable=0 -> IDLE. FIFO and counters are untouched; in-flight responses are still absorbed.
- mem_req and mem_addr are registered. While mem_req=1 and mem_ready=0, mem_addr stays stable.
- Responses:
  - If discard>0: the data is dropped and discard decrements.
  - Otherwise: the data is pushed into the FIFO and outstanding decrements.
  - Accept and response in the same cycle: outstanding is unchanged.
  - The credit rule guarantees no push into a full FIFO; a push while full is a verification error.
- Pixel output, latency 1 cycle from de_in:
  - de_in=1, FIFO non-empty: pop; RGB <= head.
  - de_in=1, FIFO empty: RGB <= UNDERFLOW_COLOR. underflow <= 1 only in FETCH or DONE.
  - de_in=0: RGB <= 0, no pop.
- A push and a pop in the same cycle leave fifo_count unchanged. A push into an empty FIFO is not visible to a pop in that same cycle.
- clear_underflow clears underflow. If set and clear occur in the same cycle, set wins.
- fs while responses are still outstanding: exactly that many subsequent responses are discarded, so no stale pixel ever reaches the FIFO.
- Counter widths:
  - req_count is wide enough for HRES*VRES.
  - outstanding and discard are clog2(FIFO_DEPTH)+1 bits.
  - mem_addr wraps modulo 2^ADDR_W.

Test Plan (HRES=4, VRES=2, FIFO_DEPTH=4, FB_BASE=0x100, mem latency 2 unless noted):
- Reset: hold reset_n=0 for 3 cycles -> mem_req=0, RGB=0, vga_hsync=vga_vsync=1, underflow=0.
- Single frame: vsync_in 1->0, then de_in high 4 cycles on each of 2 lines; mem_rdata = low 24 bits of the address.
  - Requests 0x100..0x107 issued, exactly 8, then DONE.
  - RGB sequence 0x000100..0x000107, each 1 cycle after de_in.
  - underflow stays 0.
- Back-pressure: mem_ready=0 for 10 cycles after fs -> mem_req held at 1, mem_addr held at 0x100; outstanding never exceeds 4.
- Underflow: memory latency 20, de_in asserted 3 cycles after fs -> RGB=0xFF00FF and underflow=1; clear_underflow for 1 cycle -> underflow=0.
- Mid-fetch frame restart: second fs with 3 responses outstanding -> those 3 responses dropped; first pixel displayed after restart is 0x000100.
- Enable low: enable=0 during FETCH -> mem_req=0 next cycle; fs ignored until enable=1.
